// File: rtl/mul_pipeline_if.sv
// mul_pipeline_if: EX-stage issue bundle and pipeline/writeback outputs of the RV32M multiply pipeline.
interface mul_pipeline_if;
  logic        P0_RegMul;
  logic        Flush;
  logic [2:0]  Funct3;
  logic [31:0] Rs1_Data;
  logic [31:0] Rs2_Data;
  logic [4:0]  E_Rd;
  logic        P1_RegMul;
  logic [4:0]  P1_Rd;
  logic        P2_RegMul;
  logic [4:0]  P2_Rd;
  logic        WB_Valid;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  modport master (
    output P0_RegMul, Flush, Funct3, Rs1_Data, Rs2_Data, E_Rd,
    input  P1_RegMul, P1_Rd, P2_RegMul, P2_Rd, WB_Valid, WB_Rd, WB_Data
  );
  modport slave (
    input  P0_RegMul, Flush, Funct3, Rs1_Data, Rs2_Data, E_Rd,
    output P1_RegMul, P1_Rd, P2_RegMul, P2_Rd, WB_Valid, WB_Rd, WB_Data
  );
endinterface

// File: rtl/mul_pipeline.sv
// mul_pipeline: two-stage RV32M multiplier (partial products, then sum); MULH/MULHSU/MULHU when MUL_PIPELINE_MULH_EN is defined.
module mul_pipeline (
  input logic clk,
  input logic rst_n,
  mul_pipeline_if.slave bus
);
  logic       w_acc;
  logic       r_p1_v, r_p2_v;
  logic [4:0] r_p1_rd, r_p2_rd;
  logic [31:0] r_ll;
`ifdef MUL_PIPELINE_MULH_EN
  logic              w_as, w_bs;
  logic signed [33:0] w_al, w_ah, w_bl, w_bh;
  logic signed [33:0] r_lh, r_hl, r_hh;
  logic [2:0]        r_p1_f3, r_p2_f3;
  logic [63:0]       w_sum, r_prod;
  assign w_acc = bus.P0_RegMul & ~bus.Flush & ~bus.Funct3[2];
  assign w_as  = bus.Funct3[1:0] == 2'b01 || bus.Funct3[1:0] == 2'b10;
  assign w_bs  = bus.Funct3[1:0] == 2'b01;
  // 33-bit extended operands split into unsigned low 16 and signed high 17 bits
  assign w_al  = {18'b0, bus.Rs1_Data[15:0]};
  assign w_bl  = {18'b0, bus.Rs2_Data[15:0]};
  assign w_ah  = {{18{w_as & bus.Rs1_Data[31]}}, bus.Rs1_Data[31:16]};
  assign w_bh  = {{18{w_bs & bus.Rs2_Data[31]}}, bus.Rs2_Data[31:16]};
  assign w_sum = {32'b0, r_ll} + ({{30{r_lh[33]}}, r_lh} << 16) + ({{30{r_hl[33]}}, r_hl} << 16)
               + ({{30{r_hh[33]}}, r_hh} << 32);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ll    <= '0;
      r_lh    <= '0;
      r_hl    <= '0;
      r_hh    <= '0;
      r_p1_f3 <= '0;
      r_p2_f3 <= '0;
      r_prod  <= '0;
    end else begin
      r_ll    <= {16'b0, bus.Rs1_Data[15:0]} * {16'b0, bus.Rs2_Data[15:0]};
      r_lh    <= w_al * w_bh;
      r_hl    <= w_ah * w_bl;
      r_hh    <= w_ah * w_bh;
      r_p1_f3 <= bus.Funct3;
      r_p2_f3 <= r_p1_f3;
      r_prod  <= w_sum;
    end
  end
  assign bus.WB_Data = !r_p2_v ? 32'b0 : r_p2_f3 == 3'b000 ? r_prod[31:0] : r_prod[63:32];
`else
  logic [15:0] r_lh, r_hl;
  logic [31:0] w_sum, r_prod;
  assign w_acc = bus.P0_RegMul & ~bus.Flush & bus.Funct3 == 3'b000;
  // cross products only reach the low word through their low 16 bits; the high product never does
  assign w_sum = r_ll + {r_lh + r_hl, 16'b0};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ll   <= '0;
      r_lh   <= '0;
      r_hl   <= '0;
      r_prod <= '0;
    end else begin
      r_ll   <= {16'b0, bus.Rs1_Data[15:0]} * {16'b0, bus.Rs2_Data[15:0]};
      r_lh   <= bus.Rs1_Data[15:0] * bus.Rs2_Data[31:16];
      r_hl   <= bus.Rs1_Data[31:16] * bus.Rs2_Data[15:0];
      r_prod <= w_sum;
    end
  end
  assign bus.WB_Data = r_p2_v ? r_prod : 32'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p1_v  <= 1'b0;
      r_p2_v  <= 1'b0;
      r_p1_rd <= '0;
      r_p2_rd <= '0;
    end else begin
      r_p1_v  <= w_acc;
      r_p2_v  <= r_p1_v;
      r_p1_rd <= bus.E_Rd;
      r_p2_rd <= r_p1_rd;
    end
  end
  assign bus.P1_RegMul = r_p1_v;
  assign bus.P1_Rd     = r_p1_rd;
  assign bus.P2_RegMul = r_p2_v;
  assign bus.P2_Rd     = r_p2_rd;
  assign bus.WB_Rd     = r_p2_rd;
  assign bus.WB_Valid  = r_p2_v && r_p2_rd != 5'd0;
endmodule

// File: tb/tb_mul_pipeline.sv
// tb_mul_pipeline: directed vectors for mul_pipeline; MULH cases run when MUL_PIPELINE_MULH_EN is defined.
module tb_mul_pipeline;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  mul_pipeline_if bus ();
  mul_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic fl);
    bus.P0_RegMul = 1'b1;
    bus.Flush     = fl;
    bus.Funct3    = f3;
    bus.Rs1_Data  = a;
    bus.Rs2_Data  = b;
    bus.E_Rd      = rd;
  endtask
  task automatic idle();
    bus.P0_RegMul = 1'b0;
    bus.Flush     = 1'b0;
    bus.Funct3    = 3'b000;
    bus.Rs1_Data  = 32'h0;
    bus.Rs2_Data  = 32'h0;
    bus.E_Rd      = 5'd0;
  endtask
  initial begin
    rst_n = 1'b0;
    issue(3'b000, 32'h1234_5678, 32'h9, 5'd7, 1'b0);
    step();
    step();
    chk("rst_p1v", bus.P1_RegMul, 0);
    chk("rst_p2v", bus.P2_RegMul, 0);
    chk("rst_p1rd", bus.P1_Rd, 0);
    chk("rst_wbv", bus.WB_Valid, 0);
    chk("rst_wbrd", bus.WB_Rd, 0);
    chk("rst_wbd", bus.WB_Data, 0);
    rst_n = 1'b1;
    issue(3'b000, 32'h7, 32'h6, 5'd5, 1'b0);
    step();
    chk("mul_p1v", bus.P1_RegMul, 1);
    chk("mul_p1rd", bus.P1_Rd, 5);
    chk("mul_wbv_early", bus.WB_Valid, 0);
    idle();
    step();
    chk("mul_wbv", bus.WB_Valid, 1);
    chk("mul_wbrd", bus.WB_Rd, 5);
    chk("mul_wbd", bus.WB_Data, 32'h2A);
    chk("mul_p2rd", bus.P2_Rd, 5);
    chk("mul_p1v_clr", bus.P1_RegMul, 0);
    issue(3'b000, 32'h3, 32'h5, 5'd1, 1'b0);
    step();
    issue(3'b000, 32'hA, 32'hA, 5'd2, 1'b0);
    step();
    chk("b2b_p1rd2", bus.P1_Rd, 2);
    chk("b2b_p2rd1", bus.P2_Rd, 1);
    chk("b2b_wbv1", bus.WB_Valid, 1);
    chk("b2b_wbd1", bus.WB_Data, 32'd15);
    issue(3'b000, 32'h0001_2345, 32'h2, 5'd3, 1'b0);
    step();
    chk("b2b_p1rd3", bus.P1_Rd, 3);
    chk("b2b_wbrd2", bus.WB_Rd, 2);
    chk("b2b_wbd2", bus.WB_Data, 32'd100);
    idle();
    step();
    chk("b2b_wbv3", bus.WB_Valid, 1);
    chk("b2b_wbrd3", bus.WB_Rd, 3);
    chk("b2b_wbd3", bus.WB_Data, 32'h0002_468A);
    step();
    chk("b2b_wbv_end", bus.WB_Valid, 0);
    chk("b2b_wbd_end", bus.WB_Data, 0);
    issue(3'b000, 32'h2, 32'h3, 5'd6, 1'b0);
    step();
    issue(3'b000, 32'h9, 32'h9, 5'd4, 1'b1);
    step();
    chk("fl_p1v", bus.P1_RegMul, 0);
    chk("fl_wbrd6", bus.WB_Rd, 6);
    chk("fl_wbd6", bus.WB_Data, 32'd6);
    issue(3'b000, 32'h4, 32'h5, 5'd7, 1'b0);
    step();
    chk("fl_p2v", bus.P2_RegMul, 0);
    chk("fl_wbv", bus.WB_Valid, 0);
    chk("fl_p1rd7", bus.P1_Rd, 7);
    idle();
    step();
    chk("fl_wbrd7", bus.WB_Rd, 7);
    chk("fl_wbd7", bus.WB_Data, 32'd20);
    issue(3'b000, 32'h5, 32'h5, 5'd0, 1'b0);
    step();
    chk("rd0_p1v", bus.P1_RegMul, 1);
    idle();
    step();
    chk("rd0_p2v", bus.P2_RegMul, 1);
    chk("rd0_wbv", bus.WB_Valid, 0);
    issue(3'b100, 32'h8, 32'h2, 5'd8, 1'b0);
    step();
    chk("div_p1v", bus.P1_RegMul, 0);
    idle();
    step();
    chk("div_wbv", bus.WB_Valid, 0);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0);
    step();
    idle();
    step();
    chk("mulff_wbd", bus.WB_Data, 32'h1);
    issue(3'b000, 32'h1, 32'h1, 5'd9, 1'b0);
    step();
    rst_n = 1'b0;
    idle();
    step();
    chk("rmid_p1v", bus.P1_RegMul, 0);
    chk("rmid_p2v", bus.P2_RegMul, 0);
    chk("rmid_p1rd", bus.P1_Rd, 0);
    chk("rmid_p2rd", bus.P2_Rd, 0);
    chk("rmid_wbv", bus.WB_Valid, 0);
    chk("rmid_wbrd", bus.WB_Rd, 0);
    chk("rmid_wbd", bus.WB_Data, 0);
    issue(3'b000, 32'h3, 32'h3, 5'd10, 1'b0);
    step();
    chk("rissue_p1v", bus.P1_RegMul, 0);
    rst_n = 1'b1;
    idle();
    step();
    chk("rissue_wbv", bus.WB_Valid, 0);
`ifdef MUL_PIPELINE_MULH_EN
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b0);
    step();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0);
    step();
    chk("mulh_wbd", bus.WB_Data, 32'h0);
    chk("mulh_wbv", bus.WB_Valid, 1);
    issue(3'b010, 32'hFFFF_FFFF, 32'h2, 5'd13, 1'b0);
    step();
    chk("mulhu_wbd", bus.WB_Data, 32'hFFFF_FFFE);
    issue(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd14, 1'b0);
    step();
    chk("mulhsu_wbd", bus.WB_Data, 32'hFFFF_FFFF);
    idle();
    step();
    chk("mul_min_wbd", bus.WB_Data, 32'h0);
    chk("mul_min_wbrd", bus.WB_Rd, 14);
`else
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0);
    step();
    chk("nomulh_p1v", bus.P1_RegMul, 0);
    idle();
    step();
    chk("nomulh_wbv", bus.WB_Valid, 0);
    chk("nomulh_wbd", bus.WB_Data, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_pipeline.md
MUL_PIPELINE -- requirements
Module: mul_pipeline

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock, first port), rst_n input 1 (synchronous active-low reset, second port).
REQ-002 The block SHALL have these remaining ports:
- P0_RegMul input 1: a MUL-class op is in EX this cycle (issue).
- Flush input 1: kills the EX op this cycle.
- Funct3 input 3: RV32M funct3 of the EX op.
- Rs1_Data input 32: operand A.
- Rs2_Data input 32: operand B.
- E_Rd input 5: destination of the EX op.
- P1_RegMul output 1: stage-1 valid.
- P1_Rd output 5: stage-1 destination.
- P2_RegMul output 1: stage-2 valid.
- P2_Rd output 5: stage-2 destination.
- WB_Valid output 1: result write request.
- WB_Rd output 5: write destination.
- WB_Data output 32: write data.

Function
REQ-003 Accept condition: the op SHALL be accepted into stage 1 when P0_RegMul=1, Flush=0 and Funct3[2]=0. Flush=1 wins over P0_RegMul. Funct3[2]=1 (DIV/REM) SHALL NOT be accepted.
REQ-004 Stage 1 SHALL capture these registers on the next rising edge after acceptance:
- P1_RegMul=1.
- P1_Rd=E_Rd.
- Funct3.
- Partial products of 33-bit extended operands.
P1_RegMul SHALL be 0 after any cycle with no acceptance.
REQ-005 Operand extension SHALL be:
- 000 MUL: either extension (low word only).
- 001 MULH: A signed, B signed.
- 010 MULHSU: A signed, B unsigned.
- 011 MULHU: A unsigned, B unsigned.
REQ-006 Stage 1 SHALL split each operand into a low 16-bit half and a high 17-bit half and register the four partial products.
REQ-007 Stage 2 SHALL register the 64-bit two's-complement sum of the shifted partial products, plus P2_RegMul=P1_RegMul, P2_Rd=P1_Rd and Funct3. Bits above 64 SHALL be discarded.
REQ-008 WB_Data SHALL be combinational from stage 2: product[31:0] for 000, product[63:32] for 001/010/011.
REQ-009 Writeback signals:
- WB_Rd = P2_Rd.
- WB_Valid = P2_RegMul && P2_Rd != 0.
- WB_Data = 0 when P2_RegMul=0.
REQ-010 Latency: an op accepted in cycle N SHALL show P1_RegMul in N+1 and P2_RegMul plus WB_Valid in N+2. The pipeline SHALL never stall internally.
REQ-011 Back-to-back ops SHALL be accepted every cycle. Each op SHALL keep its own Rd and Funct3 with no cross-stage mixing.
REQ-012 Flush SHALL affect only the EX op. Ops already in stage 1 or stage 2 SHALL complete.
REQ-013 Rd=0 ops SHALL propagate valid through P1/P2 but SHALL never assert WB_Valid.
REQ-014 The block SHALL ignore any front-end stall. The hazard unit guarantees no register-file write conflict while P1_RegMul=1.

Reset
REQ-015 When rst_n=0 at a rising edge, the block SHALL clear P1_RegMul, P2_RegMul, P1_Rd, P2_Rd, and all stage data and Funct3 registers to 0. WB_Valid, WB_Rd and WB_Data therefore read 0 in the following cycle.
REQ-016 Reset SHALL win over a simultaneous issue. Ops in flight at reset SHALL be discarded without writeback.
REQ-017 The first acceptance SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-018 Macro MUL_PIPELINE_MULH_EN:
- Defined: all four funct3 000–011 are supported per REQ-005/REQ-008.
- Undefined: only funct3 000 is accepted; 001–011 behave like Funct3[2]=1 (not accepted, no valid). Stage 1 stores only the three partial products needed for the low 32 bits. Stage 2 holds a 32-bit sum. WB_Data is always the low word.

Verification
REQ-019 Issue MUL with A=0x0000_0007, B=0x0000_0006, Rd=5 in cycle N -> P1_RegMul=1/P1_Rd=5 at N+1; WB_Valid=1, WB_Rd=5, WB_Data=0x0000_002A at N+2.
REQ-020 With macro defined: MULH 0xFFFF_FFFF×0xFFFF_FFFF -> 0x0000_0000; MULHU same operands -> 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF×0x0000_0002 -> 0xFFFF_FFFF; MUL 0x8000_0000×0x8000_0000 -> 0x0000_0000.
REQ-021 Three consecutive issues Rd=1,2,3 with distinct operands -> WB_Valid for three consecutive cycles; Rd and data in order; P1_Rd/P2_Rd track each op.
REQ-022 Issue with Flush=1 (Rd=4) between two valid issues -> bubble: P1_RegMul=0 then P2_RegMul=0 for that slot; neighbouring results unaffected. An Rd=0 issue -> P1/P2 valid but WB_Valid=0.
REQ-023 Issue in cycle N, rst_n=0 in N+1 -> all outputs 0 in N+2; no WB_Valid. Issue together with rst_n=0 -> not accepted.
REQ-024 Macro undefined: MULHU 0xFFFF_FFFF×0xFFFF_FFFF -> P1_RegMul stays 0, no writeback; MUL 0xFFFF_FFFF×0xFFFF_FFFF -> WB_Data=0x0000_0001.
